// File: rtl/fifo_pkg.sv
// Shared FIFO package: skid-buffer depth and occupancy encoding.
// Used by the read-side drain stage and by the FIFO testbenches.
package fifo_pkg;
  localparam int SKID_DEPTH = 2;

  // Encoded so that the enum value equals the number of held words
  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry register buffer for the read stream. Entry 0 is the head and
// drives the stream outputs directly.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             i_push,
  input  logic [DSIZE-1:0] i_data,
  input  logic             i_pop,
  output occ_t             o_occ,
  output logic [DSIZE-1:0] o_data,
  output logic             o_valid
);

  occ_t             r_occ;
  logic [DSIZE-1:0] r_d0;
  logic [DSIZE-1:0] r_d1;
  logic             r_vld;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_occ <= OCC_EMPTY;
      r_vld <= 1'b0;
      r_d0  <= '0;
      r_d1  <= '0;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (i_push) begin
            r_d0  <= i_data;
            r_occ <= OCC_ONE;
            r_vld <= 1'b1;
          end
        end
        OCC_ONE: begin
          case ({i_push, i_pop})
            2'b11: r_d0 <= i_data;
            2'b10: begin
              r_d1  <= i_data;
              r_occ <= OCC_TWO;
            end
            2'b01: begin
              r_occ <= OCC_EMPTY;
              r_vld <= 1'b0;
            end
            default: ;
          endcase
        end
        OCC_TWO: begin
          // Head shifts on every pop; a simultaneous push refills the tail
          if (i_pop) begin
            r_d0 <= r_d1;
            if (i_push) r_d1  <= i_data;
            else        r_occ <= OCC_ONE;
          end
        end
        default: begin
          r_occ <= OCC_EMPTY;
          r_vld <= 1'b0;
        end
      endcase
    end
  end

  assign o_occ   = r_occ;
  assign o_data  = r_d0;
  assign o_valid = r_vld;

  always @(posedge rclk) begin
    if (rrst_n) begin
      a_no_ovf: assert (!(r_occ == OCC_TWO && i_push && !i_pop));
      a_no_udf: assert (!(r_occ == OCC_EMPTY && i_pop));
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pops the async FIFO and drives a registered
// valid/ready stream. Optional saturating delivery counter: FIFO_RD_STATS_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DSIZE  = 8,
  parameter int RD_LAT = 0,
  parameter int CNT_W  = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] fifo_rdata,
  input  logic             fifo_rempty,
  output logic             fifo_r_valid,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_W-1:0] rd_count
`endif
);

  occ_t       w_occ;
  logic       w_deq;
  logic       w_pop;
  logic       w_push;
  logic       w_inflight;
  logic [1:0] w_sum;

  assign w_deq = m_valid & m_ready;
  assign w_sum = 2'(w_occ) + {1'b0, w_inflight};

  // Credit check: occ+inflight-deq < 2. A deq always frees a slot because
  // deq implies occ >= 1, so the subtraction never needs to wrap.
  assign w_pop        = !fifo_rempty & (w_deq | (w_sum < 2'd2));
  assign fifo_r_valid = w_pop;

  if (RD_LAT == 0) begin : g_lat0
    assign w_inflight = 1'b0;
    assign w_push     = w_pop;
  end else begin : g_lat1
    logic r_inflight;
    always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) r_inflight <= 1'b0;
      else         r_inflight <= w_pop;
    end
    assign w_inflight = r_inflight;
    assign w_push     = r_inflight;
  end

  fifo_rd_skid #(.DSIZE(DSIZE)) u_skid (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .i_push  (w_push),
    .i_data  (fifo_rdata),
    .i_pop   (w_deq),
    .o_occ   (w_occ),
    .o_data  (m_data),
    .o_valid (m_valid)
  );

`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)                   r_cnt <= '0;
    else if (w_deq && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end
  assign rd_count = r_cnt;
`endif

  always @(posedge rclk) begin
    if (rrst_n) begin
      a_credit: assert (w_sum <= 2'(SKID_DEPTH));
      a_cfg:    assert ((RD_LAT == 0 || RD_LAT == 1) && CNT_W > 0);
    end
  end

endmodule
